// File: rtl/mem_dma_if.sv
// Memory-port bundle for the DMA engine: command/status handshake plus the
// single-port RAM strobes, address and data.
interface mem_dma_if #(
   parameter int LEN_WIDTH = 9
);
   // Handshake: start is a single-cycle request, honoured only while the
   // engine is idle (busy=0 and done=0). The engine owns the memory port
   // while busy=1. Every accepted request ends with a 1-cycle done pulse
   // (err qualifies it), unless abort or rst cancels the transfer first.
   logic                 start;
   logic                 mode;
   logic                 abort;
   logic [31:0]          src_addr;
   logic [31:0]          dst_addr;
   logic [LEN_WIDTH-1:0] len_words;
   logic [31:0]          fill_data;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 MemRd;
   logic                 MemWr;
   logic [31:0]          Addr;
   logic [31:0]          WrData;
   logic [31:0]          RdData;

   modport master (
      input  start, mode, abort, src_addr, dst_addr, len_words, fill_data, RdData,
      output busy, done, err, MemRd, MemWr, Addr, WrData
   );

   modport slave (
      output start, mode, abort, src_addr, dst_addr, len_words, fill_data, RdData,
      input  busy, done, err, MemRd, MemWr, Addr, WrData
   );
endinterface

// File: rtl/mem_dma_master.sv
// Word-granular copy/fill engine driving the data-memory port. Copy is one
// read followed by one write per word; fill issues back-to-back writes.
module mem_dma_master #(
   parameter int LEN_WIDTH = 9
) (
   input  logic       clk,
   input  logic       rst,
   mem_dma_if.master  bus,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t               state;
   logic [31:0]          cur_src;
   logic [31:0]          cur_dst;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 mode_r;
   logic [31:0]          fill_r;
   logic [31:0]          dst_next;
   logic                 misaligned;

   assign dst_next   = cur_dst + 32'd4;
   assign misaligned = (bus.dst_addr[1:0] != 2'b00) ||
                       (!bus.mode && (bus.src_addr[1:0] != 2'b00));
   assign dbg_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_src    <= '0;
         cur_dst    <= '0;
         cnt        <= '0;
         mode_r     <= 1'b0;
         fill_r     <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.MemRd  <= 1'b0;
         bus.MemWr  <= 1'b0;
         bus.Addr   <= '0;
         bus.WrData <= '0;
      end else begin
         // Outputs fall back to idle every cycle; each branch re-asserts what
         // the next state drives, so abort and FINISH need no extra clearing.
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
         bus.MemRd  <= 1'b0;
         bus.MemWr  <= 1'b0;
         bus.Addr   <= '0;
         bus.WrData <= '0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  cur_src <= bus.src_addr;
                  cur_dst <= bus.dst_addr;
                  cnt     <= bus.len_words;
                  mode_r  <= bus.mode;
                  fill_r  <= bus.fill_data;
                  if (misaligned) begin
                     state    <= FINISH;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else if (bus.len_words == '0) begin
                     state    <= FINISH;
                     bus.done <= 1'b1;
                  end else if (!bus.mode) begin
                     state     <= READ;
                     bus.busy  <= 1'b1;
                     bus.MemRd <= 1'b1;
                     bus.Addr  <= bus.src_addr;
                  end else begin
                     state      <= WRITE;
                     bus.busy   <= 1'b1;
                     bus.MemWr  <= 1'b1;
                     bus.Addr   <= bus.dst_addr;
                     bus.WrData <= bus.fill_data;
                  end
               end
            end
            READ: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  // WrData doubles as the copy buffer for the word just read.
                  cur_src    <= cur_src + 32'd4;
                  state      <= WRITE;
                  bus.busy   <= 1'b1;
                  bus.MemWr  <= 1'b1;
                  bus.Addr   <= cur_dst;
                  bus.WrData <= bus.RdData;
               end
            end
            WRITE: begin
               if (bus.abort) begin
                  state <= IDLE;
               end else begin
                  cur_dst <= dst_next;
                  cnt     <= cnt - LEN_WIDTH'(1);
                  if (cnt == LEN_WIDTH'(1)) begin
                     state    <= FINISH;
                     bus.done <= 1'b1;
                  end else if (!mode_r) begin
                     state     <= READ;
                     bus.busy  <= 1'b1;
                     bus.MemRd <= 1'b1;
                     bus.Addr  <= cur_src;
                  end else begin
                     bus.busy   <= 1'b1;
                     bus.MemWr  <= 1'b1;
                     bus.Addr   <= dst_next;
                     bus.WrData <= fill_r;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed bench for mem_dma_master: RAM model on the port, write scoreboard
// fed from a reference copy/fill model, latency and strobe checks per step.
module tb_mem_dma_master;
   localparam int LW = 9;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] dbg_state;

   mem_dma_if #(.LEN_WIDTH(LW)) bus ();

   mem_dma_master #(.LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // RAM: 1024 words, byte address bits [11:2] select the word
   logic [31:0] ram   [1024];
   logic [31:0] model [1024];
   logic        pre_we;
   logic [9:0]  pre_idx;
   logic [31:0] pre_val;

   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] = pre_val;
      if (bus.MemWr) ram[bus.Addr[11:2]] = bus.WrData;
   end

   assign bus.RdData = bus.MemRd ? ram[bus.Addr[11:2]] : 32'h0;

   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   int overlap_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every write strobe must match the next expected write
   always @(negedge clk) begin : mon
      logic [63:0] e;
      if (bus.MemRd || bus.MemWr) acc_cnt++;
      if (bus.MemRd && bus.MemWr) overlap_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.MemWr) begin
         check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", bus.Addr, e[63:32]);
            check("wr_data", bus.WrData, e[31:0]);
         end
      end
   end

   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(posedge clk);
      #1 pre_we = 1'b0;
      model[idx] = val;
   endtask

   // Reference model: ascending word-by-word, first n words only
   task automatic model_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input int n, input logic [31:0] f);
      logic [31:0] sa, da, v;
      sa = s;
      da = d;
      for (int i = 0; i < n; i++) begin
         v = m ? f : model[sa[11:2]];
         model[da[11:2]] = v;
         exp_q.push_back({da, v});
         sa = sa + 32'd4;
         da = da + 32'd4;
      end
   endtask

   task automatic start_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input logic [LW-1:0] n, input logic [31:0] f);
      @(negedge clk);
      bus.mode      = m;
      bus.src_addr  = s;
      bus.dst_addr  = d;
      bus.len_words = n;
      bus.fill_data = f;
      bus.abort     = 1'b0;
      bus.start     = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts negedges after the start edge until done; bounded
   task automatic wait_done(output int cyc, output logic got, output logic e);
      got = 1'b0;
      e   = 1'b0;
      cyc = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.done) begin
            got = 1'b1;
            e   = bus.err;
         end
      end
   endtask

   initial begin
      int cyc;
      logic got, e;
      int b0, a0, o0, d0;
      logic [31:0] pat;

      rst = 1'b1;
      pre_we = 1'b0;
      pre_idx = '0;
      pre_val = '0;
      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.abort = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.len_words = '0;
      bus.fill_data = '0;
      repeat (3) @(posedge clk);
      preload(10'd0, 32'h0000_0014);
      preload(10'd1, 32'h0000_41A8);
      preload(10'd2, 32'h0000_3AF2);
      preload(10'd3, 32'h0000_ACDA);
      for (int i = 4; i < 8; i++) preload(10'(i), $urandom);

      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_memrd", bus.MemRd, 0);
      check("rst_memwr", bus.MemWr, 0);
      check("rst_addr", bus.Addr, 0);
      check("rst_wrdata", bus.WrData, 0);
      check("rst_state", dbg_state, S_IDLE);
      rst = 1'b0;

      // copy 4 words 0x0 -> 0x100
      b0 = busy_cnt;
      o0 = overlap_cnt;
      model_xfer(1'b0, 32'h0, 32'h100, 4, 32'h0);
      start_xfer(1'b0, 32'h0, 32'h100, 9'd4, 32'h0);
      wait_done(cyc, got, e);
      check("t1_done_seen", got, 1);
      check("t1_latency", cyc, 9);
      check("t1_err", e, 0);
      check("t1_busy_cycles", busy_cnt - b0, 8);
      @(negedge clk);
      check("t1_done_width", bus.done, 0);
      check("t1_overlap", overlap_cnt - o0, 0);
      check("t1_ram0", ram[10'h40], 32'h0000_0014);
      check("t1_ram1", ram[10'h41], 32'h0000_41A8);
      check("t1_ram2", ram[10'h42], 32'h0000_3AF2);
      check("t1_ram3", ram[10'h43], 32'h0000_ACDA);
      check("t1_queue", exp_q.size(), 0);

      // fill 3 words at 0x200
      a0 = acc_cnt;
      model_xfer(1'b1, 32'h0, 32'h200, 3, 32'hDEAD_BEEF);
      start_xfer(1'b1, 32'h0, 32'h200, 9'd3, 32'hDEAD_BEEF);
      wait_done(cyc, got, e);
      check("t2_done_seen", got, 1);
      check("t2_latency", cyc, 4);
      check("t2_err", e, 0);
      check("t2_accesses", acc_cnt - a0, 3);
      check("t2_ram2", ram[10'h82], 32'hDEAD_BEEF);
      check("t2_queue", exp_q.size(), 0);

      // zero length and misaligned requests: done next cycle, no access
      a0 = acc_cnt;
      start_xfer(1'b0, 32'h0, 32'h300, 9'd0, 32'h0);
      wait_done(cyc, got, e);
      check("t3_zero_latency", cyc, 1);
      check("t3_zero_err", e, 0);
      start_xfer(1'b1, 32'h0, 32'h102, 9'd2, 32'h1234);
      wait_done(cyc, got, e);
      check("t3_dst_latency", cyc, 1);
      check("t3_dst_err", e, 1);
      start_xfer(1'b0, 32'h1, 32'h300, 9'd2, 32'h0);
      wait_done(cyc, got, e);
      check("t3_src_latency", cyc, 1);
      check("t3_src_err", e, 1);
      @(negedge clk);
      check("t3_no_access", acc_cnt - a0, 0);

      // copy 5 words 0x0 -> 0x80, abort in the 2nd WRITE with a start also raised
      d0 = done_cnt;
      model_xfer(1'b0, 32'h0, 32'h80, 2, 32'h0);
      start_xfer(1'b0, 32'h0, 32'h80, 9'd5, 32'h0);
      repeat (4) @(negedge clk);
      check("t4_in_write", dbg_state, S_WRITE);
      bus.abort     = 1'b1;
      bus.start     = 1'b1;
      bus.mode      = 1'b1;
      bus.dst_addr  = 32'h300;
      bus.len_words = 9'd1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      a0 = acc_cnt;
      check("t4_busy", bus.busy, 0);
      check("t4_state", dbg_state, S_IDLE);
      repeat (5) @(negedge clk);
      check("t4_no_done", done_cnt - d0, 0);
      check("t4_no_access", acc_cnt - a0, 0);
      check("t4_ram20", ram[10'h20], model[10'h20]);
      check("t4_ram21", ram[10'h21], model[10'h21]);
      check("t4_queue", exp_q.size(), 0);

      // forward-overlapping copy, then fill wrapping past 0xFFFFFFFC
      preload(10'd0, 32'hA5A5_0001);
      model_xfer(1'b0, 32'h0, 32'h4, 3, 32'h0);
      start_xfer(1'b0, 32'h0, 32'h4, 9'd3, 32'h0);
      wait_done(cyc, got, e);
      check("t5_latency", cyc, 7);
      check("t5_ram1", ram[10'd1], 32'hA5A5_0001);
      check("t5_ram3", ram[10'd3], 32'hA5A5_0001);
      pat = $urandom;
      model_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 2, pat);
      start_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 9'd2, pat);
      wait_done(cyc, got, e);
      check("t5_wrap_latency", cyc, 3);
      check("t5_wrap_ram0", ram[10'd0], pat);
      check("t5_queue", exp_q.size(), 0);

      // reset during READ, then a normal copy
      start_xfer(1'b0, 32'h0, 32'h180, 9'd2, 32'h0);
      @(negedge clk);
      check("t6_in_read", dbg_state, S_READ);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_busy", bus.busy, 0);
      check("t6_memrd", bus.MemRd, 0);
      check("t6_memwr", bus.MemWr, 0);
      check("t6_addr", bus.Addr, 0);
      check("t6_done", bus.done, 0);
      check("t6_state", dbg_state, S_IDLE);
      model_xfer(1'b0, 32'h0, 32'h180, 2, 32'h0);
      start_xfer(1'b0, 32'h0, 32'h180, 9'd2, 32'h0);
      wait_done(cyc, got, e);
      check("t6_latency", cyc, 5);
      check("t6_err", e, 0);
      check("t6_ram61", ram[10'h61], model[10'h61]);
      check("t6_queue", exp_q.size(), 0);
      check("all_no_overlap", overlap_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
